// File: rtl/display_pkg.sv
// display_pkg: shared state encoding and anode constants for the digit display scheduler
package display_pkg;
  typedef enum logic [1:0] {GAP_R, SHOW_L, GAP_L, SHOW_R} disp_state_t;
  localparam logic [1:0] ANODE_OFF     = 2'b11;
  localparam logic [1:0] ANODE_LEFT_N  = 2'b01;
  localparam logic [1:0] ANODE_RIGHT_N = 2'b10;
  // Encoding order matches the refresh cycle, so advancing is a 2-bit wrap
  function automatic disp_state_t next_state(disp_state_t s);
    return disp_state_t'(s + 2'd1);
  endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts 0..last_i and pulses done_o on the final count, then restarts at 0
module dwell_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] last_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q == last_i;
  assign cnt_d  = done_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/digit_display_ctrl.sv
// digit_display_ctrl: two-digit key history with blanked time-multiplexing of a shared
// seven-segment decoder across the left and right anodes
module digit_display_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       clear,
  output logic [3:0] seg_digit,
  output logic [1:0] anode_n,
  output logic [7:0] history
);
  localparam int MAXC = REFRESH_CYCLES > BLANK_CYCLES ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int W = $clog2(MAXC);
  localparam logic [W-1:0] SHOW_LAST = W'(REFRESH_CYCLES - 1);
  localparam logic [W-1:0] GAP_LAST  = W'(BLANK_CYCLES - 1);
  if (REFRESH_CYCLES < 2 || BLANK_CYCLES < 1) begin : g_bad_param
    $error("digit_display_ctrl: REFRESH_CYCLES must be >= 2 and BLANK_CYCLES >= 1");
  end
  disp_state_t state_q, state_d;
  logic        done;
  logic [3:0]  left_q, left_d, right_q, right_d;
  logic        lvld_q, lvld_d, rvld_q, rvld_d;
  dwell_counter #(.W(W)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .last_i ((state_q == SHOW_L || state_q == SHOW_R) ? SHOW_LAST : GAP_LAST),
    .done_o (done)
  );
  always_comb begin
    state_d = done ? next_state(state_q) : state_q;
    left_d  = clear ? 4'h0 : key_valid ? right_q : left_q;
    lvld_d  = clear ? 1'b0 : key_valid ? rvld_q : lvld_q;
    right_d = clear ? 4'h0 : key_valid ? key_digit : right_q;
    rvld_d  = clear ? 1'b0 : key_valid ? 1'b1 : rvld_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= GAP_R;
      left_q  <= 4'h0;
      right_q <= 4'h0;
      lvld_q  <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      lvld_q  <= lvld_d;
      rvld_q  <= rvld_d;
    end
  // Left value is preloaded during GAP_R so the decoder settles before the anode turns on
  assign seg_digit = (state_q == GAP_R || state_q == SHOW_L) ? left_q : right_q;
  assign anode_n   = (state_q == SHOW_L && lvld_q) ? ANODE_LEFT_N :
                     (state_q == SHOW_R && rvld_q) ? ANODE_RIGHT_N : ANODE_OFF;
  assign history   = {left_q, right_q};
endmodule
